// File: rtl/vend_pkg.sv
// Shared types and coin constants for the vending credit controller.
// DOLLAR_COIN_EN adds a 100-cent coin and raises the default credit ceiling.
package vend_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } state_t;

  localparam int COIN5   = 5;
  localparam int COIN10  = 10;
  localparam int COIN25  = 25;
  localparam int COIN100 = 100;

`ifdef DOLLAR_COIN_EN
  localparam int MAX_DEFAULT = 195;
`else
  localparam int MAX_DEFAULT = 95;
`endif

endpackage

// File: rtl/vend_coin_decode.sv
// Coin strobe decoder: reports any strobe, one-hot validity and coin value.
// DOLLAR_COIN_EN adds the c100 strobe.
module vend_coin_decode
  import vend_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         c5,
  input  logic         c10,
  input  logic         c25,
`ifdef DOLLAR_COIN_EN
  input  logic         c100,
`endif
  output logic         any,
  output logic         valid,
  output logic [W-1:0] value
);

  logic [3:0] hot;

`ifdef DOLLAR_COIN_EN
  assign hot = {c100, c25, c10, c5};
`else
  assign hot = {1'b0, c25, c10, c5};
`endif

  assign any   = |hot;
  assign valid = $onehot(hot);

  always_comb begin
    value = '0;
    unique case (hot)
      4'b0001: value = W'(COIN5);
      4'b0010: value = W'(COIN10);
      4'b0100: value = W'(COIN25);
      4'b1000: value = W'(COIN100);
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending credit controller: collects coins, requests a vend, pays change.
// DOLLAR_COIN_EN adds the c100 coin input and a 195-cent default ceiling.
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int BITS       = 8,
  parameter int PRICE      = 25,
  parameter int MAX_CREDIT = MAX_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            c5,
  input  logic            c10,
  input  logic            c25,
`ifdef DOLLAR_COIN_EN
  input  logic            c100,
`endif
  input  logic            cancel,
  input  logic            vend_ack,
  output logic            vend_req,
  output logic            nickel_out,
  output logic            coin_reject,
  output logic [BITS-1:0] credit,
  output logic            busy
);

  localparam logic [BITS:0] PRICE_W = (BITS+1)'(PRICE);
  localparam logic [BITS:0] MAX_W   = (BITS+1)'(MAX_CREDIT);
  localparam logic [BITS-1:0] NICKEL = BITS'(COIN5);

  state_t        state;
  logic          any;
  logic          valid;
  logic [BITS:0] value;
  logic [BITS:0] cur;
  logic [BITS:0] sum;
  logic [BITS:0] diff;
  logic          fits;
  logic          stop;
  logic          take;
  logic          reject;

  vend_coin_decode #(
    .W(BITS+1)
  ) u_dec (
    .c5   (c5),
    .c10  (c10),
    .c25  (c25),
`ifdef DOLLAR_COIN_EN
    .c100 (c100),
`endif
    .any  (any),
    .valid(valid),
    .value(value)
  );

  // One extra bit so the ceiling compare cannot be fooled by wrap.
  assign cur  = {1'b0, credit};
  assign sum  = cur + value;
  assign diff = cur - PRICE_W;
  assign fits = (sum <= MAX_W);

  assign stop = (state == COLLECT) && cancel && (credit != '0);
  assign take = (state == COLLECT) && enable && valid && !stop && fits;
  assign reject = any && !take;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= COLLECT;
      credit      <= '0;
      vend_req    <= 1'b0;
      nickel_out  <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      coin_reject <= reject;
      nickel_out  <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (take)
            credit <= sum[BITS-1:0];
          // Refund beats a pending vend.
          if (stop) begin
            state <= CHANGE;
            busy  <= 1'b1;
          end else if (cur >= PRICE_W) begin
            state    <= VEND;
            vend_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        VEND: begin
          if (vend_ack) begin
            vend_req <= 1'b0;
            credit   <= diff[BITS-1:0];
            if (diff == '0) begin
              state <= COLLECT;
              busy  <= 1'b0;
            end else begin
              state <= CHANGE;
            end
          end
        end
        CHANGE: begin
          credit     <= credit - NICKEL;
          nickel_out <= 1'b1;
          if (credit == NICKEL) begin
            state <= COLLECT;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= COLLECT;
          credit   <= '0;
          vend_req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Bench for vend_credit_ctrl: two instances against a cents-level model.
// Directed scenarios pin the model; random traffic covers the rest.
module tb_vend_credit_ctrl;

  localparam int MC = 0;
  localparam int MV = 1;
  localparam int MH = 2;

  logic clk = 1'b0;
  logic reset, enable, c5, c10, c25, cancel, vend_ack;
`ifdef DOLLAR_COIN_EN
  logic c100 = 1'b0;
`endif

  logic       vreq [2];
  logic       nick [2];
  logic       rej  [2];
  logic [7:0] cred [2];
  logic       bsy  [2];

  int m_price [2] = '{25, 95};
  int m_max   [2] = '{95, 95};
  int m_mode  [2] = '{MC, MC};
  int m_cr    [2] = '{0, 0};
  int m_rej   [2] = '{0, 0};
  int m_nk    [2] = '{0, 0};

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vend_credit_ctrl u_a (
    .clk(clk), .reset(reset), .enable(enable),
    .c5(c5), .c10(c10), .c25(c25),
`ifdef DOLLAR_COIN_EN
    .c100(c100),
`endif
    .cancel(cancel), .vend_ack(vend_ack),
    .vend_req(vreq[0]), .nickel_out(nick[0]),
    .coin_reject(rej[0]), .credit(cred[0]), .busy(bsy[0])
  );

  vend_credit_ctrl #(.PRICE(95), .MAX_CREDIT(95)) u_b (
    .clk(clk), .reset(reset), .enable(enable),
    .c5(c5), .c10(c10), .c25(c25),
`ifdef DOLLAR_COIN_EN
    .c100(c100),
`endif
    .cancel(cancel), .vend_ack(vend_ack),
    .vend_req(vreq[1]), .nickel_out(nick[1]),
    .coin_reject(rej[1]), .credit(cred[1]), .busy(bsy[1])
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_step(input int k);
    int n, val, old;
    bit acc, quit;
    n = int'(c5) + int'(c10) + int'(c25);
    val = c25 ? 25 : (c10 ? 10 : 5);
`ifdef DOLLAR_COIN_EN
    n += int'(c100);
    if (c100) val = 100;
`endif
    m_rej[k] = 0;
    m_nk[k]  = 0;
    if (reset) begin
      m_mode[k] = MC;
      m_cr[k]   = 0;
      return;
    end
    if (m_mode[k] == MC) begin
      quit = cancel && m_cr[k] > 0;
      acc = (n == 1) && enable && !quit && (m_cr[k] + val <= m_max[k]);
      m_rej[k] = (n > 0 && !acc) ? 1 : 0;
      old = m_cr[k];
      if (acc) m_cr[k] += val;
      if (quit) m_mode[k] = MH;
      else if (old >= m_price[k]) m_mode[k] = MV;
    end else if (m_mode[k] == MV) begin
      m_rej[k] = (n > 0) ? 1 : 0;
      if (vend_ack) begin
        m_cr[k] -= m_price[k];
        m_mode[k] = (m_cr[k] > 0) ? MH : MC;
      end
    end else begin
      m_rej[k] = (n > 0) ? 1 : 0;
      m_cr[k] -= 5;
      m_nk[k] = 1;
      if (m_cr[k] == 0) m_mode[k] = MC;
    end
  endtask

  task automatic compare(input int k);
    chk($sformatf("dut%0d credit", k), 32'(cred[k]), m_cr[k]);
    chk($sformatf("dut%0d vend_req", k), 32'(vreq[k]),
        (m_mode[k] == MV) ? 1 : 0);
    chk($sformatf("dut%0d busy", k), 32'(bsy[k]),
        (m_mode[k] != MC) ? 1 : 0);
    chk($sformatf("dut%0d nickel_out", k), 32'(nick[k]), m_nk[k]);
    chk($sformatf("dut%0d coin_reject", k), 32'(rej[k]), m_rej[k]);
    chk($sformatf("dut%0d ceiling", k),
        32'(int'(cred[k]) <= m_max[k]), 1);
  endtask

  task automatic step(input bit r, input bit en, input bit b5,
                      input bit b10, input bit b25, input bit can,
                      input bit ack);
    @(negedge clk);
    reset = r; enable = en; c5 = b5; c10 = b10; c25 = b25;
    cancel = can; vend_ack = ack;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic idle();
    step(0, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; enable = 0; c5 = 0; c10 = 0; c25 = 0;
    cancel = 0; vend_ack = 0;

    step(1, 0, 0, 0, 0, 0, 0);
    chk("reset credit", 32'(cred[0]), 0);
    chk("reset busy", 32'(bsy[0]), 0);

    // 10 + 10 + 5 reaches the price exactly
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("exact credit", 32'(cred[0]), 25);
    idle();
    chk("exact vend_req", 32'(vreq[0]), 1);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("exact after ack", 32'(cred[0]), 0);
    chk("exact busy", 32'(bsy[0]), 0);
    idle();
    chk("exact no nickel", 32'(nick[0]), 0);

    // coin offered while vending is returned
    step(0, 1, 0, 0, 1, 0, 0);
    idle();
    step(0, 1, 0, 0, 1, 0, 0);
    chk("vend coin reject", 32'(rej[0]), 1);
    chk("vend coin credit", 32'(cred[0]), 25);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("vend coin after ack", 32'(cred[0]), 0);

    // 10 then 25 leaves two nickels of change
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    chk("change credit", 32'(cred[0]), 35);
    idle();
    step(0, 1, 0, 0, 0, 0, 1);
    chk("change remainder", 32'(cred[0]), 10);
    idle();
    chk("change pulse1", 32'(nick[0]), 1);
    idle();
    chk("change pulse2", 32'(nick[0]), 1);
    chk("change done", 32'(cred[0]), 0);
    idle();
    chk("change quiet", 32'(nick[0]), 0);

    // cancel beats a simultaneous coin
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1, 0);
    chk("cancel reject", 32'(rej[0]), 1);
    chk("cancel credit", 32'(cred[0]), 15);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("cancel pulse", 32'(nick[0]), 1);
    end
    chk("cancel done", 32'(cred[0]), 0);

    // multi-hot strobe, then ceiling overflow on the 95-cent instance
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0);
    chk("multihot reject", 32'(rej[0]), 1);
    chk("multihot credit", 32'(cred[0]), 0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("ceiling credit", 32'(cred[1]), 90);
    step(0, 1, 0, 1, 0, 0, 0);
    chk("ceiling reject", 32'(rej[1]), 1);
    chk("ceiling hold", 32'(cred[1]), 90);

    // reset in the middle of paying change
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    chk("midchange busy", 32'(bsy[0]), 1);
    chk("midchange credit", 32'(cred[0]), 20);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("reset credit mid", 32'(cred[0]), 0);
    chk("reset nickel mid", 32'(nick[0]), 0);
    chk("reset busy mid", 32'(bsy[0]), 0);
    idle();
    chk("reset no pulse", 32'(nick[0]), 0);

    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_credit_ctrl.md
VEND_CREDIT_CTRL -- requirements
Module: vend_credit_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 8, width of credit datapath.
REQ-002 SHALL have parameter PRICE, default 25, item price in cents; multiple of 5, at least 5.
REQ-003 SHALL have parameter MAX_CREDIT, default 95, highest credit accepted; multiple of 5, at least PRICE, less than 2**BITS.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 enable  input  1  coin acceptance enable.
REQ-008 c5, c10, c25  input  1 each  coin-present strobes, one cycle per coin.
REQ-009 cancel  input  1  refund request.
REQ-010 vend_ack  input  1  dispenser accepted the vend.
REQ-011 vend_req  output  1  request item dispense.
REQ-012 nickel_out  output  1  one-cycle pulse per 5-cent change coin.
REQ-013 coin_reject  output  1  one-cycle pulse, coin returned.
REQ-014 credit  output  BITS  current credit in cents.
REQ-015 busy  output  1  high in VEND or CHANGE.

Function
REQ-016 SHALL implement states COLLECT, VEND and CHANGE.
REQ-017 COLLECT: a single asserted coin strobe with enable high SHALL add 5, 10 or 25 to credit on the next edge.
REQ-018 Multi-hot strobes, enable low, or credit+value > MAX_CREDIT SHALL leave credit unchanged and pulse coin_reject the next cycle.
REQ-019 COLLECT with credit >= PRICE SHALL go to VEND on the next edge; coins that cycle are still added.
REQ-020 VEND: vend_req SHALL be held high until vend_ack is sampled high.
REQ-021 On vend_ack, credit SHALL drop by PRICE; go to CHANGE if the remainder is > 0, else COLLECT.
REQ-022 CHANGE: nickel_out SHALL pulse every cycle with credit dropping by 5 on the same edge; go to COLLECT on the edge credit reaches 0.
REQ-023 cancel in COLLECT with credit > 0 SHALL go to CHANGE; cancel with credit 0, in VEND, or in CHANGE SHALL be ignored.
REQ-024 Coin and cancel in the same COLLECT cycle: cancel wins, coin rejected.
REQ-025 Any coin strobe in VEND or CHANGE SHALL be rejected.
REQ-026 vend_ack outside VEND SHALL be ignored.
REQ-027 credit SHALL never wrap or exceed MAX_CREDIT.
REQ-028 Credit arithmetic SHALL use BITS+1 bits internally before the compare.

Reset
REQ-029 Reset SHALL force COLLECT, credit 0, and vend_req, nickel_out, coin_reject and busy low on the next edge.
REQ-030 Reset in any state, including mid-CHANGE, SHALL discard remaining credit with no further pulses.

Configuration
REQ-031 With DOLLAR_COIN_EN defined, input c100 SHALL exist with value 100, and the default MAX_CREDIT SHALL become 195.
REQ-032 Without DOLLAR_COIN_EN, c100 SHALL be absent and all logic SHALL match REQ-017..028.

Structure
REQ-033 Package vend_pkg SHALL hold the state enum and coin value constants (5, 10, 25, 100).
REQ-034 Sub-module vend_coin_decode SHALL map strobes to {valid, value}, with valid low on multi-hot.

Verification
REQ-035 Coins 10, 10, 5 -> credit 25, VEND, vend_req high; vend_ack -> credit 0, COLLECT, no nickel_out.
REQ-036 Coins 25 then 25 in the VEND cycle -> second coin rejected; after ack credit 0.
REQ-037 Coins 25 at credit 10 -> credit 35, VEND; ack -> 2 nickel_out pulses in consecutive cycles, then COLLECT.
REQ-038 Credit 15, cancel together with c5 -> coin_reject; 3 nickel_out pulses; credit 0.
REQ-039 c5 and c10 together -> coin_reject, credit unchanged; coin at credit 90 with MAX_CREDIT 95 and c10 -> rejected.
REQ-040 Reset asserted mid-CHANGE with credit 20 -> next cycle credit 0, COLLECT, nickel_out low.
